// File: rtl/alu_issuer_if.sv
// alu_issuer_if: host request/response and control-unit handshake bundle for alu_issuer
interface alu_issuer_if #(parameter int WIDTH = 8);
  logic             req_valid, req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a, req_b;
  logic             start;
  logic [1:0]       opcode;
  logic [WIDTH-1:0] op_a, op_b;
  logic             done;
  logic [WIDTH-1:0] res_lo, res_hi;
  logic             rsp_valid, rsp_ready;
  logic [1:0]       rsp_op;
  logic [WIDTH-1:0] rsp_lo, rsp_hi;
  logic             rsp_err;
  logic             busy;
  modport slave (
    input  req_valid, req_op, req_a, req_b, done, res_lo, res_hi, rsp_ready,
    output req_ready, start, opcode, op_a, op_b, rsp_valid, rsp_op, rsp_lo, rsp_hi, rsp_err, busy
  );
  modport master (
    output req_valid, req_op, req_a, req_b, done, res_lo, res_hi, rsp_ready,
    input  req_ready, start, opcode, op_a, op_b, rsp_valid, rsp_op, rsp_lo, rsp_hi, rsp_err, busy
  );
endinterface

// File: rtl/alu_issuer.sv
// alu_issuer: single-outstanding ALU request issuer with done timeout and divide-by-zero short-cut
module alu_issuer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input logic         clk,
  input logic         reset,
  alu_issuer_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       opcode_q, opcode_d, rsp_op_q, rsp_op_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, rsp_lo_q, rsp_lo_d, rsp_hi_q, rsp_hi_d;
  logic             rsp_err_q, rsp_err_d;
  logic             req_ready_q, start_q, busy_q, rsp_valid_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opcode_d = opcode_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    rsp_op_d = rsp_op_q;
    rsp_lo_d = rsp_lo_q;
    rsp_hi_d = rsp_hi_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        rsp_op_d = bus.req_op;
        if (bus.req_op == 2'b11 && bus.req_b == '0) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
          rsp_lo_d  = '1;
          rsp_hi_d  = '1;
        end else begin
          state_d  = ISSUE;
          opcode_d = bus.req_op;
          op_a_d   = bus.req_a;
          op_b_d   = bus.req_b;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (bus.done) begin
        state_d   = RESP;
        rsp_err_d = 1'b0;
        rsp_lo_d  = bus.res_lo;
        rsp_hi_d  = bus.res_hi;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d   = RESP;
        rsp_err_d = 1'b1;
        rsp_lo_d  = '0;
        rsp_hi_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      opcode_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_op_q    <= '0;
      rsp_lo_q    <= '0;
      rsp_hi_q    <= '0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b1;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_op_q    <= rsp_op_d;
      rsp_lo_q    <= rsp_lo_d;
      rsp_hi_q    <= rsp_hi_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= state_d == IDLE;
      start_q     <= state_d == ISSUE;
      busy_q      <= state_d != IDLE;
      rsp_valid_q <= state_d == RESP;
    end
  end
  assign bus.req_ready = req_ready_q;
  assign bus.start     = start_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.opcode    = opcode_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.rsp_lo    = rsp_lo_q;
  assign bus.rsp_hi    = rsp_hi_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_alu_issuer.sv
// tb_alu_issuer: table-driven transactions plus backpressure and mid-operation reset sequences
module tb_alu_issuer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int starts = 0;
  alu_issuer_if #(.WIDTH(8)) bus ();
  alu_issuer #(.WIDTH(8), .TIMEOUT(64)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.start === 1'b1) starts++;
  typedef struct {
    logic [1:0] op;
    logic [7:0] a, b;
    int         dly;
    logic [7:0] res_lo, res_hi;
    logic       err;
    logic [7:0] lo, hi;
  } vec_t;
  vec_t vecs[7];
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_reset_vals();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_op", {bus.opcode, bus.op_a, bus.op_b}, 0);
    chk("rst_rsp", {bus.rsp_op, bus.rsp_err, bus.rsp_hi, bus.rsp_lo}, 0);
  endtask
  task automatic run(input vec_t v);
    int s0;
    s0 = starts;
    bus.req_valid = 1'b1;
    bus.req_op = v.op;
    bus.req_a = v.a;
    bus.req_b = v.b;
    bus.res_lo = v.res_lo;
    bus.res_hi = v.res_hi;
    chk("req_ready_idle", bus.req_ready, 1);
    cyc();
    bus.req_valid = 1'b0;
    if (v.dly < 0) begin
      chk("div0_start", bus.start, 0);
    end else begin
      chk("issue_start", bus.start, 1);
      chk("issue_busy", bus.busy, 1);
      chk("issue_req_ready", bus.req_ready, 0);
      cyc();
      for (int i = 0; i < v.dly; i++) begin
        chk("wait_start", bus.start, 0);
        chk("wait_rsp_valid", bus.rsp_valid, 0);
        chk("wait_op_stable", {bus.opcode, bus.op_a, bus.op_b}, {v.op, v.a, v.b});
        cyc();
      end
      if (v.dly < 64) begin
        bus.done = 1'b1;
        cyc();
        bus.done = 1'b0;
      end
    end
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_op", bus.rsp_op, v.op);
    chk("rsp_err", bus.rsp_err, v.err);
    chk("rsp_lo", bus.rsp_lo, v.lo);
    chk("rsp_hi", bus.rsp_hi, v.hi);
    chk("start_pulses", starts - s0, v.dly < 0 ? 0 : 1);
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_req_ready", bus.req_ready, 1);
  endtask
  initial begin
    vecs[0] = '{2'b00, 8'h12, 8'h34, 1,  8'h46, 8'h00, 1'b0, 8'h46, 8'h00};
    vecs[1] = '{2'b01, 8'h50, 8'h20, 0,  8'h30, 8'h00, 1'b0, 8'h30, 8'h00};
    vecs[2] = '{2'b10, 8'h0F, 8'h11, 9,  8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00};
    vecs[3] = '{2'b11, 8'h20, 8'h00, -1, 8'h5A, 8'hA5, 1'b1, 8'hFF, 8'hFF};
    vecs[4] = '{2'b11, 8'h64, 8'h07, 63, 8'h0E, 8'h02, 1'b0, 8'h0E, 8'h02};
    vecs[5] = '{2'b01, 8'h05, 8'h01, 64, 8'hAA, 8'hBB, 1'b1, 8'h00, 8'h00};
    vecs[6] = '{2'b10, 8'hFF, 8'hFF, 3,  8'h01, 8'hFE, 1'b0, 8'h01, 8'hFE};
    bus.req_valid = 1'b0;
    bus.req_op = 2'b00;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.done = 1'b0;
    bus.res_lo = '0;
    bus.res_hi = '0;
    bus.rsp_ready = 1'b0;
    cyc();
    cyc();
    chk_reset_vals();
    reset = 1'b1;
    cyc();
    bus.done = 1'b1;
    cyc();
    chk("idle_done_no_rsp", bus.rsp_valid, 0);
    chk("idle_done_busy", bus.busy, 0);
    bus.done = 1'b0;
    foreach (vecs[k]) run(vecs[k]);
    bus.req_valid = 1'b1;
    bus.req_op = 2'b00;
    bus.req_a = 8'h01;
    bus.req_b = 8'h02;
    cyc();
    bus.req_valid = 1'b0;
    cyc();
    bus.done = 1'b1;
    bus.res_lo = 8'h03;
    bus.res_hi = 8'h00;
    cyc();
    bus.req_valid = 1'b1;
    bus.req_op = 2'b01;
    bus.req_a = 8'h09;
    bus.req_b = 8'h04;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_stable", {bus.rsp_op, bus.rsp_err, bus.rsp_hi, bus.rsp_lo}, {2'b00, 1'b0, 8'h00, 8'h03});
      chk("bp_req_ready", bus.req_ready, 0);
      cyc();
    end
    bus.done = 1'b0;
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    chk("bp_idle_ready", bus.req_ready, 1);
    chk("bp_idle_valid", bus.rsp_valid, 0);
    cyc();
    bus.req_valid = 1'b0;
    chk("bp_second_start", bus.start, 1);
    chk("bp_second_op", {bus.opcode, bus.op_a, bus.op_b}, {2'b01, 8'h09, 8'h04});
    cyc();
    bus.done = 1'b1;
    bus.res_lo = 8'h05;
    cyc();
    bus.done = 1'b0;
    chk("bp_second_rsp", {bus.rsp_valid, bus.rsp_op, bus.rsp_err, bus.rsp_lo}, {1'b1, 2'b01, 1'b0, 8'h05});
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op = 2'b10;
    bus.req_a = 8'h07;
    bus.req_b = 8'h03;
    cyc();
    bus.req_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("mid_wait_busy", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk_reset_vals();
    cyc();
    bus.done = 1'b1;
    bus.res_lo = 8'h15;
    cyc();
    reset = 1'b1;
    chk("rel_req_ready", bus.req_ready, 1);
    cyc();
    cyc();
    chk("rel_no_rsp", bus.rsp_valid, 0);
    chk("rel_busy", bus.busy, 0);
    bus.done = 1'b0;
    run(vecs[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Parameter WIDTH, default 8, operand/result half width.
REQ-002 Parameter TIMEOUT, default 64, max cycles waiting for done before abort.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-005 req_valid  in  1  host request present.
REQ-006 req_ready  out  1  issuer accepts request this cycle.
REQ-007 req_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-008 req_a, req_b  in  WIDTH  operands.
REQ-009 start  out  1  one-cycle pulse to control unit.
REQ-010 opcode  out  2  operation to control unit, held stable from start through completion.
REQ-011 op_a, op_b  out  WIDTH  operands to datapath, held stable like opcode.
REQ-012 done  in  1  completion level from control unit.
REQ-013 res_lo, res_hi  in  WIDTH  datapath result (MUL: {hi,lo} product; DIV: lo quotient, hi remainder; ADD/SUB: lo).
REQ-014 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-015 rsp_op  out  2; rsp_lo, rsp_hi  out  WIDTH; rsp_err  out  1  response payload.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-018 req_ready shall equal (state==IDLE); request accepted on req_valid&req_ready.
REQ-019 On acceptance with non-error request: latch op/a/b into opcode/op_a/op_b, go ISSUE; start=1 only during the ISSUE cycle.
REQ-020 ISSUE -> WAIT unconditionally after one cycle; done ignored during ISSUE and the acceptance cycle.
REQ-021 In WAIT, first cycle done=1 sampled: capture res_lo/res_hi into rsp_lo/rsp_hi, rsp_err=0, go RESP; rsp_valid=1 next cycle.
REQ-022 Latency: accept at cycle N -> start at N+1 -> earliest rsp_valid at N+3 (done high at N+2).
REQ-023 WAIT counter clears on entry, increments each WAIT cycle without done; done sampled in the cycle the counter reaches TIMEOUT-1 still completes normally; otherwise at TIMEOUT-1 go RESP with rsp_err=1, rsp_lo=rsp_hi=0.
REQ-024 Divide-by-zero: accepted req_op=11 with req_b=0 shall skip ISSUE/WAIT, never pulse start, go RESP next cycle with rsp_err=1, rsp_lo=rsp_hi=all ones.
REQ-025 rsp_op equals the accepted req_op for every response, including errors.
REQ-026 In RESP, rsp_valid=1 and all rsp_* stable until rsp_valid&rsp_ready; then IDLE next cycle, rsp_valid=0.
REQ-027 Single outstanding operation; req_valid in non-IDLE states is not accepted and has no effect.
REQ-028 done high while IDLE or RESP has no effect.

Reset
REQ-029 reset=0 forces: state IDLE, start=0, rsp_valid=0, rsp_err=0, busy=0, opcode=00, op_a=op_b=0, rsp_lo=rsp_hi=0, rsp_op=00, WAIT counter 0.
REQ-030 Reset during ISSUE/WAIT/RESP aborts the operation with no response; req_ready=1 in first cycle after release.
REQ-031 reset is synchronised by its caller for release; no internal synchroniser.

Verification
REQ-032 ADD a=8'h12 b=8'h34, done 2 cycles after start, res_lo=8'h46 -> one start pulse, rsp_valid with rsp_op=00, rsp_lo=8'h46, rsp_err=0.
REQ-033 MUL a=8'h0F b=8'h11, done after 9 WAIT cycles, res={8'h00,8'hFF} -> rsp_hi=8'h00, rsp_lo=8'hFF, opcode/op_a/op_b stable throughout.
REQ-034 DIV a=8'h20 b=0 -> start never asserted, rsp_valid 1 cycle after accept, rsp_err=1, rsp_lo=rsp_hi=8'hFF.
REQ-035 SUB with done held low, TIMEOUT=64 -> rsp_err=1, rsp_lo=rsp_hi=0, rsp_valid exactly 64 cycles after entering WAIT.
REQ-036 rsp_ready held low 5 cycles with second req_valid pending -> response stable, req_ready=0; second request accepted cycle after handshake.
REQ-037 reset=0 mid-WAIT with done arriving later -> no rsp_valid, all outputs at REQ-029 values, next request completes normally.
